// File: rtl/mac_feed_ctrl.sv
// mac_feed_ctrl: operand feeder and result collector for a pipelined saturating MAC.
// Rev 1.0 - initial release.
`default_nettype none

module mac_feed_ctrl #(
  parameter int INW      = 16,
  parameter int OUTW     = 48,
  parameter int K        = 8,
  parameter int MULT_LAT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [INW-1:0]  in_a,
  input  logic [INW-1:0]  in_b,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [INW-1:0]  mac_in0,
  output logic [INW-1:0]  mac_in1,
  output logic            mac_valid_input,
  output logic            mac_clear_acc,
  input  logic [OUTW-1:0] mac_out,
  output logic [OUTW-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int              IDXW     = (K > 1) ? $clog2(K) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(K - 1);
  localparam int              VD       = MULT_LAT;
  localparam int              CD       = MULT_LAT + 1;
  localparam int              LD       = MULT_LAT + 2;

  logic [IDXW-1:0] idx_q, idx_d;
  logic [VD-1:0]   vline_q, vline_d;
  logic [CD-1:0]   cline_q, cline_d;
  logic [LD-1:0]   lline_q, lline_d;
  logic [OUTW-1:0] out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            at_last;
  logic            accept;

  assign at_last = (idx_q == LAST_IDX);
  // Only a vector's last pair can stall: its result needs a free output slot.
  assign in_ready = !(at_last && (out_valid_q || (|lline_q)));
  assign accept   = in_valid && in_ready;

  always_comb begin
    idx_d = idx_q;
    if (accept) begin
      idx_d = at_last ? '0 : idx_q + IDXW'(1);
    end

    vline_d    = '0;
    cline_d    = '0;
    lline_d    = '0;
    vline_d[0] = accept;
    cline_d[0] = accept && (idx_q == '0);
    lline_d[0] = accept && at_last;
    for (int i = 1; i < VD; i++) vline_d[i] = vline_q[i-1];
    for (int i = 1; i < CD; i++) cline_d[i] = cline_q[i-1];
    for (int i = 1; i < LD; i++) lline_d[i] = lline_q[i-1];

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (lline_q[LD-1]) begin
      out_valid_d = 1'b1;
      out_data_d  = mac_out;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q       <= '0;
      vline_q     <= '0;
      cline_q     <= '0;
      lline_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      vline_q     <= vline_d;
      cline_q     <= cline_d;
      lline_q     <= lline_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign mac_in0         = in_a;
  assign mac_in1         = in_b;
  assign mac_valid_input = vline_q[VD-1];
  assign mac_clear_acc   = cline_q[CD-1];
  assign out_data        = out_data_q;
  assign out_valid       = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_feed_ctrl.sv
// tb_mac_feed_ctrl: two controllers (OUTW=48 and OUTW=32, K=4) each driving a behavioural MAC.
`default_nettype none

module tb_mac_feed_ctrl;

  localparam int INW = 16;
  localparam int K   = 4;
  localparam int ML  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic signed [INW-1:0] in_a = '0, in_b = '0;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, in_ready32;
  logic signed [INW-1:0] mi0, mi1, mi0_32, mi1_32;
  logic mvalid, mclear, mvalid32, mclear32;
  logic signed [47:0] mac_out48, out_data48;
  logic signed [31:0] mac_out32, out_data32;
  logic out_valid48, out_valid32;

  mac_feed_ctrl #(.INW(INW), .OUTW(48), .K(K), .MULT_LAT(ML)) u_dut (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_ready(in_ready), .mac_in0(mi0), .mac_in1(mi1), .mac_valid_input(mvalid),
    .mac_clear_acc(mclear), .mac_out(mac_out48), .out_data(out_data48),
    .out_valid(out_valid48), .out_ready(out_ready));

  mac_feed_ctrl #(.INW(INW), .OUTW(32), .K(K), .MULT_LAT(ML)) u_dut32 (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_ready(in_ready32), .mac_in0(mi0_32), .mac_in1(mi1_32), .mac_valid_input(mvalid32),
    .mac_clear_acc(mclear32), .mac_out(mac_out32), .out_data(out_data32),
    .out_valid(out_valid32), .out_ready(out_ready));

  function automatic longint sat(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Behavioural MAC: ML-stage multiplier, gated product register, saturating accumulator.
  longint p48[ML], prod48, acc48, p32[ML], prod32, acc32;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ML; i++) begin p48[i] <= 0; p32[i] <= 0; end
      prod48 <= 0; acc48 <= 0; prod32 <= 0; acc32 <= 0;
    end else begin
      p48[0] <= longint'(mi0) * longint'(mi1);
      p32[0] <= longint'(mi0_32) * longint'(mi1_32);
      for (int i = 1; i < ML; i++) begin p48[i] <= p48[i-1]; p32[i] <= p32[i-1]; end
      prod48 <= mvalid ? p48[ML-1] : 0;
      prod32 <= mvalid32 ? p32[ML-1] : 0;
      acc48  <= mclear ? prod48 : sat(acc48 + prod48, 48);
      acc32  <= mclear32 ? prod32 : sat(acc32 + prod32, 32);
    end
  end
  assign mac_out48 = acc48[47:0];
  assign mac_out32 = acc32[31:0];

  int errors = 0, checks = 0;
  int cyc = 0, clear_cyc = -1, out_cyc = -1, vcount = 0;
  longint q48[$], q32[$];
  longint e48, e32;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitors: pop an expected result whenever a DUT hands one over.
  always @(negedge clk) begin
    if (mvalid) vcount++;
    if (mclear) clear_cyc = cyc;
    if (!reset && out_valid48 && out_ready) begin
      if (q48.size() == 0) begin
        checks++; errors++;
        $display("FAIL out48_spurious: got %0d expected no result", out_data48);
      end else begin
        e48 = q48.pop_front();
        check("out48", longint'(out_data48), e48);
        out_cyc = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid32 && out_ready) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL out32_spurious: got %0d expected no result", out_data32);
      end else begin
        e32 = q32.pop_front();
        check("out32", longint'(out_data32), e32);
      end
    end
  end

  function automatic void push(input longint x48, input longint x32);
    q48.push_back(x48);
    q32.push_back(x32);
  endfunction

  // Called 1ns after a posedge; returns 1ns after the posedge that accepted the pair.
  task automatic send(input int a, input int b, output int t, output int st);
    in_a = INW'(a); in_b = INW'(b); in_valid = 1'b1; st = 0;
    @(negedge clk);
    while ((!in_ready || !in_ready32) && st < 60) begin st++; @(negedge clk); end
    if (!in_ready || !in_ready32) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=%0d expected 1", in_ready);
    end
    t = cyc;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && (q48.size() != 0 || q32.size() != 0); i++) @(negedge clk);
    if (q48.size() != 0 || q32.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q48.size() + q32.size());
      q48.delete(); q32.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int t0, t, st;
  int va[4] = '{1, 2, 3, 4};
  int vb[4] = '{5, 6, 7, 8};
  int gaps[4] = '{2, 0, 5, 3};

  initial begin
    @(negedge clk); @(negedge clk);
    check("rst_out_valid", out_valid48, 0);
    check("rst_out_data", out_data48, 0);
    check("rst_mac_valid", mvalid, 0);
    check("rst_mac_clear", mclear, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single vector, latency of clear strobe and result
    out_ready = 1'b1;
    send(1, 5, t0, st);
    send(2, 6, t, st);
    send(3, 7, t, st);
    send(4, 8, t, st);
    push(70, 70);
    idle(1);
    wait_drain();
    check("t1_clear_lat", clear_cyc - t0, 4);
    check("t1_out_lat", out_cyc - t, 6);

    // Back-to-back vectors; the second last pair waits for the first result to leave
    for (int i = 0; i < 4; i++) send(va[i], vb[i], t, st);
    push(70, 70);
    for (int i = 0; i < 3; i++) send(-1, 2, t, st);
    send(-1, 2, t, st);
    check("t2_last_stall", st, 3);
    push(-8, -8);
    idle(1);
    wait_drain();

    // Bubbles between pairs
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      if (gaps[i] > 0) idle(gaps[i]);
      send(va[i], vb[i], t, st);
    end
    push(70, 70);
    idle(1);
    wait_drain();
    idle(2);
    check("t3_valid_count", vcount, 4);

    // Back-pressure from the output
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(va[i], vb[i], t, st);
    push(70, 70);
    for (int i = 0; i < 3; i++) send(-1, 2, t, st);
    in_a = -1; in_b = 2; in_valid = 1'b1;
    repeat (10) @(negedge clk);
    check("t4_stall_ready", in_ready, 0);
    check("t4_held_valid", out_valid48, 1);
    check("t4_held_data", out_data48, 70);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(-1, 2, t, st);
    push(-8, -8);
    idle(1);
    wait_drain();

    // Saturation in the 32-bit MAC passes straight through
    for (int i = 0; i < 4; i++) send(-32768, -32768, t, st);
    push(64'sd4294967296, 64'sd2147483647);
    idle(1);
    wait_drain();

    // Reset mid-vector with strobes in flight
    send(9, 9, t, st);
    send(9, 9, t, st);
    in_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("t6_rst_out_valid", out_valid48, 0);
    check("t6_rst_out_data48", out_data48, 0);
    check("t6_rst_out_data32", out_data32, 0);
    check("t6_rst_mac_valid", mvalid, 0);
    check("t6_rst_mac_clear", mclear, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(1, 3, t, st);
    push(12, 12);
    idle(1);
    wait_drain();
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
